// File: rtl/divisor_seq_pkg.sv
// Shared definitions for the sequential divider: state encoding and default sizes.
package divisor_seq_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CNT_W = 6;

  // Like the Booth multiplier, results land in the MIPS HI/LO pair:
  // DIV puts the quotient in LO and the remainder in HI.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/divisor_seq_step.sv
// One restoring-division iteration: shift {rem,quo} left, trial-subtract the divisor,
// and keep the difference when it does not go negative.
module divisor_seq_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_dvs,
  output logic [WIDTH:0]   o_rem,
  output logic [WIDTH-1:0] o_quo
);

  logic [WIDTH:0] w_rem_sh;
  logic [WIDTH:0] w_trial;
  logic           w_ge;

  assign w_rem_sh = {i_rem[WIDTH-1:0], i_quo[WIDTH-1]};
  assign w_trial  = w_rem_sh - {1'b0, i_dvs};
  // A set top bit means the shifted value already exceeds any divisor.
  assign w_ge     = i_rem[WIDTH] || (w_rem_sh >= {1'b0, i_dvs});

  assign o_rem = w_ge ? w_trial : w_rem_sh;
  assign o_quo = {i_quo[WIDTH-2:0], w_ge};

endmodule

// File: rtl/divisor_seq.sv
// Signed sequential divider for DIV: quotient to LO (low), remainder to HI (high).
// One quotient bit per cycle on magnitudes, then one sign-fix cycle; 34 cycles start to done.
module divisor_seq
  import divisor_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] high,
  output logic [WIDTH-1:0] low,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  state_t             r_state, w_state;
  logic [WIDTH:0]     r_rem, w_rem;
  logic [WIDTH-1:0]   r_quo, w_quo;
  logic [WIDTH-1:0]   r_dvs, w_dvs;
  logic               r_sa, w_sa;
  logic               r_sb, w_sb;
  logic [CNT_W-1:0]   r_count, w_count;
  logic [WIDTH-1:0]   r_high, w_high;
  logic [WIDTH-1:0]   r_low, w_low;
  logic               r_done, w_done;
  logic               r_div_zero, w_div_zero;

  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [WIDTH:0]     w_step_rem;
  logic [WIDTH-1:0]   w_step_quo;

  // The most negative value negates to itself, which is its correct unsigned magnitude.
  assign w_abs_a = A[WIDTH-1] ? -A : A;
  assign w_abs_b = B[WIDTH-1] ? -B : B;

  divisor_seq_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_rem (r_rem),
    .i_quo (r_quo),
    .i_dvs (r_dvs),
    .o_rem (w_step_rem),
    .o_quo (w_step_quo)
  );

  always_comb begin
    w_state    = r_state;
    w_rem      = r_rem;
    w_quo      = r_quo;
    w_dvs      = r_dvs;
    w_sa       = r_sa;
    w_sb       = r_sb;
    w_count    = r_count;
    w_high     = r_high;
    w_low      = r_low;
    w_done     = 1'b0;
    w_div_zero = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          if (B == '0) begin
            w_done     = 1'b1;
            w_div_zero = 1'b1;
          end else begin
            w_sa    = A[WIDTH-1];
            w_sb    = B[WIDTH-1];
            w_dvs   = w_abs_b;
            w_quo   = w_abs_a;
            w_rem   = '0;
            w_count = '0;
            w_state = CALC;
          end
        end
      end
      CALC: begin
        w_rem   = w_step_rem;
        w_quo   = w_step_quo;
        w_count = r_count + CNT_W'(1);
        if (r_count == CNT_W'(WIDTH - 1)) begin
          w_state = FIX;
        end
      end
      FIX: begin
        w_low   = (r_sa ^ r_sb) ? -r_quo : r_quo;
        w_high  = r_sa ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];
        w_done  = 1'b1;
        w_state = IDLE;
      end
      default: w_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_rem      <= '0;
      r_quo      <= '0;
      r_dvs      <= '0;
      r_sa       <= 1'b0;
      r_sb       <= 1'b0;
      r_count    <= '0;
      r_high     <= '0;
      r_low      <= '0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_rem      <= w_rem;
      r_quo      <= w_quo;
      r_dvs      <= w_dvs;
      r_sa       <= w_sa;
      r_sb       <= w_sb;
      r_count    <= w_count;
      r_high     <= w_high;
      r_low      <= w_low;
      r_done     <= w_done;
      r_div_zero <= w_div_zero;
    end
  end

  assign high     = r_high;
  assign low      = r_low;
  assign busy     = (r_state != IDLE);
  assign done     = r_done;
  assign div_zero = r_div_zero;

endmodule

// File: tb/tb_divisor_seq.sv
// Directed bench for divisor_seq: signs, boundaries, divide-by-zero, busy-start, reset abort.
module tb_divisor_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] high;
  logic [31:0] low;
  logic        busy;
  logic        done;
  logic        div_zero;

  int checks = 0;
  int errors = 0;

  divisor_seq dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .A        (A),
    .B        (B),
    .high     (high),
    .low      (low),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the following negedge (cycle 1 of the operation).
  task automatic launch(input logic [31:0] a, input logic [31:0] b);
    A = a;
    B = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    A = $urandom;
    B = $urandom;
  endtask

  // Counts cycles from lat0 until done; busy must stay high on every cycle before done.
  task automatic wait_done(input int lat0, output int lat, output bit bsy_ok);
    lat = lat0;
    bsy_ok = 1'b1;
    while (!done && lat < 100) begin
      if (!busy) bsy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp_lo, input logic [31:0] exp_hi);
    int lat;
    bit bsy_ok;
    launch(a, b);
    wait_done(1, lat, bsy_ok);
    chk({tag, " latency"}, 32'(lat), 32'd34);
    chk({tag, " busy during op"}, {31'd0, bsy_ok}, 32'd1);
    chk({tag, " busy at done"}, {31'd0, busy}, 32'd0);
    chk({tag, " low"}, low, exp_lo);
    chk({tag, " high"}, high, exp_hi);
    chk({tag, " div_zero"}, {31'd0, div_zero}, 32'd0);
  endtask

  initial begin
    int lat;
    bit bsy_ok;
    bit saw_done;

    rst = 1'b1;
    start = 1'b0;
    A = '0;
    B = '0;
    repeat (2) @(negedge clk);
    chk("reset high", high, 32'd0);
    chk("reset low", low, 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset div_zero", {31'd0, div_zero}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run("100/7", 32'd100, 32'd7, 32'd14, 32'd2);
    @(negedge clk);
    chk("done pulse width", {31'd0, done}, 32'd0);

    // Divide by zero: flagged next cycle, never busy, results untouched.
    launch(32'd5, 32'd0);
    chk("b0 done", {31'd0, done}, 32'd1);
    chk("b0 div_zero", {31'd0, div_zero}, 32'd1);
    chk("b0 busy", {31'd0, busy}, 32'd0);
    chk("b0 low kept", low, 32'd14);
    chk("b0 high kept", high, 32'd2);
    @(negedge clk);
    chk("b0 done drop", {31'd0, done}, 32'd0);
    chk("b0 div_zero drop", {31'd0, div_zero}, 32'd0);
    chk("b0 still idle", {31'd0, busy}, 32'd0);

    run("-100/7", 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE);
    run("100/-7", 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2);
    run("-100/-7", 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 32'hFFFF_FFFE);
    run("min/-1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
    run("5/9", 32'd5, 32'd9, 32'd0, 32'd5);
    run("0/7", 32'd0, 32'd7, 32'd0, 32'd0);
    // Start presented in the same cycle done is high is accepted.
    run("-7/2 b2b", 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    run("min/3", 32'h8000_0000, 32'd3, 32'hD555_5556, 32'hFFFF_FFFE);
    @(negedge clk);

    // Start while busy must be ignored.
    launch(32'd100, 32'd7);
    repeat (8) @(negedge clk);
    A = 32'd1;
    B = 32'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(10, lat, bsy_ok);
    chk("ignore latency", 32'(lat), 32'd34);
    chk("ignore busy", {31'd0, bsy_ok}, 32'd1);
    chk("ignore low", low, 32'd14);
    chk("ignore high", high, 32'd2);
    @(negedge clk);

    // Reset in the middle of an operation aborts it.
    launch(32'd100, 32'd7);
    repeat (14) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort high", high, 32'd0);
    chk("abort low", low, 32'd0);
    chk("abort busy", {31'd0, busy}, 32'd0);
    chk("abort done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    chk("abort no done", {31'd0, saw_done}, 32'd0);
    run("9/3", 32'd9, 32'd3, 32'd3, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
